// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: posted-write buffer between the EX/MEM pipeline register
// and the single-port, byte-addressed data memory. Word stores are accepted in
// one cycle, held in a circular FIFO, and drained to memory whenever the port
// is not needed by a load (or when the buffer is full). Younger loads to a
// buffered word get the youngest matching store data forwarded.
//
// Optional feature (macro STBUF_COALESCE_EN): a store to the same word as the
// youngest buffered entry overwrites that entry instead of allocating a new one.
module dmem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     st_valid,
    input  logic [AW-1:0]            st_addr,
    input  logic [DW-1:0]            st_data,
    output logic                     st_ready,
    output logic                     st_err,
    input  logic                     ld_valid,
    input  logic [AW-1:0]            ld_addr,
    output logic                     ld_hit,
    output logic [DW-1:0]            ld_fwd_data,
    output logic                     ld_stall,
    output logic [AW-1:0]            dmem_addr,
    output logic [DW-1:0]            dmem_wdata,
    output logic                     dmem_we,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int WAW = AW - 2;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    // Entry storage: word address and data. Validity comes from head/count,
    // so the storage itself needs no reset.
    logic [WAW-1:0] addr_mem [DEPTH];
    logic [DW-1:0]  data_mem [DEPTH];

    logic [PW-1:0]  head_reg;
    logic [PW-1:0]  tail_reg;
    logic [CW-1:0]  count_reg;
    state_t         state_reg;
    logic           st_err_reg;
    logic [AW-1:0]  dmem_addr_reg;
    logic [DW-1:0]  dmem_wdata_reg;
    logic           dmem_we_reg;

    logic           aligned;
    logic           push;
    logic           pop;
    logic           coal;
    logic [DEPTH-1:0] entry_match;

    // Byte offset of a load is irrelevant: forwarding is whole-word only.
    logic           ld_offset_unused;
    assign ld_offset_unused = ^ld_addr[1:0];

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign aligned = (st_addr[1:0] == 2'b00);

    // The drain owns the port when no load needs it, or when the buffer is
    // full (otherwise a full buffer plus a stream of loads would deadlock).
    assign pop = !empty && (!ld_valid || full);

`ifdef STBUF_COALESCE_EN
    logic [PW-1:0] youngest_idx;
    assign youngest_idx = tail_reg - PW'(1);
    // Merge into the youngest entry unless that entry is leaving this edge
    // (only possible when it is also the oldest, i.e. a single entry).
    assign coal = st_valid && aligned && !empty
               && (addr_mem[youngest_idx] == st_addr[AW-1:2])
               && !(pop && (count_reg == CW'(1)));
    assign st_ready = !full || coal;
`else
    assign coal     = 1'b0;
    assign st_ready = !full;
`endif

    // Allocation uses the pre-edge st_ready, so a full buffer never pushes
    // even if it pops on the same edge.
    assign push = st_valid && aligned && st_ready && !coal;

    // Per-entry validity (age from head below occupancy) and load match.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PW-1:0] age;
            logic          valid;
            assign age   = PW'(gi) - head_reg;
            assign valid = ({1'b0, age} < count_reg);
            assign entry_match[gi] = valid && (addr_mem[gi] == ld_addr[AW-1:2]);
        end
    endgenerate

    // Walk entries oldest to youngest so the youngest match is the one kept.
    always_comb begin
        logic [PW-1:0] idx;
        ld_hit      = 1'b0;
        ld_fwd_data = '0;
        idx         = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_reg + PW'(k);
            if (entry_match[idx]) begin
                ld_hit      = 1'b1;
                ld_fwd_data = data_mem[idx];
            end
        end
    end

    assign ld_stall = ld_valid && full && !ld_hit;

    // Entry writes: allocate at tail, or merge into the youngest entry.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail_reg] <= st_addr[AW-1:2];
            data_mem[tail_reg] <= st_data;
        end
`ifdef STBUF_COALESCE_EN
        if (coal) begin
            data_mem[youngest_idx] <= st_data;
        end
`endif
    end

    // FIFO pointers, occupancy and misaligned-store error pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg   <= '0;
            tail_reg   <= '0;
            count_reg  <= '0;
            st_err_reg <= 1'b0;
        end else begin
            if (push) begin
                tail_reg <= tail_reg + PW'(1);
            end
            if (pop) begin
                head_reg <= head_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            st_err_reg <= st_valid && !aligned;
        end
    end

    // Drain FSM: registers the head entry onto the memory write port; WRITE
    // holds for exactly one cycle per drained entry, back-to-back if needed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            dmem_addr_reg  <= '0;
            dmem_wdata_reg <= '0;
            dmem_we_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        dmem_addr_reg  <= {addr_mem[head_reg], 2'b00};
                        dmem_wdata_reg <= data_mem[head_reg];
                        dmem_we_reg    <= 1'b1;
                        state_reg      <= WRITE;
                    end else begin
                        dmem_we_reg    <= 1'b0;
                    end
                end
                WRITE: begin
                    if (pop) begin
                        dmem_addr_reg  <= {addr_mem[head_reg], 2'b00};
                        dmem_wdata_reg <= data_mem[head_reg];
                        dmem_we_reg    <= 1'b1;
                        state_reg      <= WRITE;
                    end else begin
                        dmem_we_reg    <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
                default: begin
                    dmem_we_reg <= 1'b0;
                    state_reg   <= IDLE;
                end
            endcase
        end
    end

    assign st_err     = st_err_reg;
    assign dmem_addr  = dmem_addr_reg;
    assign dmem_wdata = dmem_wdata_reg;
    assign dmem_we    = dmem_we_reg;
    assign count      = count_reg;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for dmem_store_buffer: a table of per-cycle vectors with
// hand-computed expectations, followed by hand-written wrap and mid-drain
// reset sequences. Expected values adapt when STBUF_COALESCE_EN is defined.
module tb_dmem_store_buffer;

`ifdef STBUF_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        st_err;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_fwd_data;
    logic        ld_stall;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_we;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    int total;
    int bad;

    dmem_store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .st_ready(st_ready), .st_err(st_err),
        .ld_valid(ld_valid), .ld_addr(ld_addr),
        .ld_hit(ld_hit), .ld_fwd_data(ld_fwd_data), .ld_stall(ld_stall),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
        .count(count), .empty(empty), .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sv;
        logic [31:0] sa;
        logic [31:0] sd;
        logic        lv;
        logic [31:0] la;
        logic        e_ready;
        logic        e_hit;
        logic [31:0] e_fwd;
        logic        e_stall;
        logic [2:0]  e_count;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_err;
    } vec_t;

    localparam int NV = 36;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                                input logic lv, input logic [31:0] la,
                                input logic rdy, input logic hit, input logic [31:0] fwd,
                                input logic stall, input int cnt, input logic we,
                                input logic [31:0] addr, input logic [31:0] wd, input logic err);
        vec_t v;
        v.sv = sv; v.sa = sa; v.sd = sd; v.lv = lv; v.la = la;
        v.e_ready = rdy; v.e_hit = hit; v.e_fwd = fwd; v.e_stall = stall;
        v.e_count = 3'(cnt); v.e_we = we; v.e_addr = addr; v.e_wdata = wd; v.e_err = err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                         input logic lv, input logic [31:0] la);
        st_valid = sv; st_addr = sa; st_data = sd; ld_valid = lv; ld_addr = la;
    endtask

    initial begin
        int pulses;
        total = 0;
        bad   = 0;

        // fields: st_valid st_addr st_data ld_valid ld_addr | ready hit fwd stall | count we addr wdata err
        // basic drain
        tbl[0]  = mk(1, 32'h08, 32'hDEADBEEF, 0, 32'h00, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 32'h00, 1, 0, 0, 0, 0, 1, 32'h08, 32'hDEADBEEF, 0);
        tbl[2]  = mk(0, 0, 0, 0, 32'h00, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        // load priority and forwarding to the same word
        tbl[3]  = mk(1, 32'h10, 32'h11111111, 1, 32'h12, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[4]  = mk(1, 32'h10, 32'h22222222, 1, 32'h12, 1, 1, 32'h11111111, 0, COAL ? 1 : 2, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 1, 32'h12, 1, 1, 32'h22222222, 0, COAL ? 1 : 2, 0, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 32'h12, 1, 1, 32'h22222222, 0, COAL ? 0 : 1, 1, 32'h10,
                     COAL ? 32'h22222222 : 32'h11111111, 0);
        tbl[7]  = mk(0, 0, 0, 0, 32'h12, 1, COAL ? 1'b0 : 1'b1, COAL ? 32'h0 : 32'h22222222, 0,
                     0, COAL ? 1'b0 : 1'b1, 32'h10, 32'h22222222, 0);
        tbl[8]  = mk(0, 0, 0, 0, 32'h00, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        // fill with loads held, then full behaviour
        tbl[9]  = mk(1, 32'h00, 32'hA0000000, 1, 32'h20, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[10] = mk(1, 32'h04, 32'hA0000001, 1, 32'h20, 1, 0, 0, 0, 2, 0, 0, 0, 0);
        tbl[11] = mk(1, 32'h08, 32'hA0000002, 1, 32'h20, 1, 0, 0, 0, 3, 0, 0, 0, 0);
        tbl[12] = mk(1, 32'h0C, 32'hA0000003, 1, 32'h20, 1, 0, 0, 0, 4, 0, 0, 0, 0);
        tbl[13] = mk(1, 32'h14, 32'hA0000004, 1, 32'h20, 0, 0, 0, 1, 3, 1, 32'h00, 32'hA0000000, 0);
        tbl[14] = mk(0, 0, 0, 1, 32'h08, 1, 1, 32'hA0000002, 0, 3, 0, 0, 0, 0);
        tbl[15] = mk(1, 32'h18, 32'hA0000005, 1, 32'h04, 1, 1, 32'hA0000001, 0, 4, 0, 0, 0, 0);
        tbl[16] = mk(0, 0, 0, 1, 32'h04, 0, 1, 32'hA0000001, 0, 3, 1, 32'h04, 32'hA0000001, 0);
        tbl[17] = mk(0, 0, 0, 1, 32'h04, 1, 0, 0, 0, 3, 0, 0, 0, 0);
        tbl[18] = mk(0, 0, 0, 0, 32'h00, 1, 0, 0, 0, 2, 1, 32'h08, 32'hA0000002, 0);
        tbl[19] = mk(0, 0, 0, 0, 32'h00, 1, 0, 0, 0, 1, 1, 32'h0C, 32'hA0000003, 0);
        tbl[20] = mk(0, 0, 0, 0, 32'h00, 1, 0, 0, 0, 0, 1, 32'h18, 32'hA0000005, 0);
        tbl[21] = mk(0, 0, 0, 0, 32'h00, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        // misaligned stores
        tbl[22] = mk(1, 32'h06, 32'h0BAD0BAD, 0, 32'h00, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[23] = mk(0, 0, 0, 0, 32'h00, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[24] = mk(1, 32'h20, 32'hC0000000, 1, 32'h00, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[25] = mk(1, 32'h21, 32'hC0000001, 1, 32'h00, 1, 0, 0, 0, 1, 0, 0, 0, 1);
        tbl[26] = mk(0, 0, 0, 0, 32'h00, 1, 0, 0, 0, 0, 1, 32'h20, 32'hC0000000, 0);
        tbl[27] = mk(0, 0, 0, 0, 32'h00, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        // youngest-match forwarding, drained entry no longer searched
        tbl[28] = mk(1, 32'h30, 32'hD0000000, 1, 32'h30, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[29] = mk(1, 32'h34, 32'hD0000001, 1, 32'h30, 1, 1, 32'hD0000000, 0, 2, 0, 0, 0, 0);
        tbl[30] = mk(1, 32'h30, 32'hD0000002, 1, 32'h30, 1, 1, 32'hD0000000, 0, 3, 0, 0, 0, 0);
        tbl[31] = mk(0, 0, 0, 1, 32'h30, 1, 1, 32'hD0000002, 0, 3, 0, 0, 0, 0);
        tbl[32] = mk(0, 0, 0, 0, 32'h30, 1, 1, 32'hD0000002, 0, 2, 1, 32'h30, 32'hD0000000, 0);
        tbl[33] = mk(0, 0, 0, 0, 32'h30, 1, 1, 32'hD0000002, 0, 1, 1, 32'h34, 32'hD0000001, 0);
        tbl[34] = mk(0, 0, 0, 0, 32'h30, 1, 1, 32'hD0000002, 0, 0, 1, 32'h30, 32'hD0000002, 0);
        tbl[35] = mk(0, 0, 0, 0, 32'h30, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        #3;
        chk("reset count", 32'(count), 0);
        chk("reset empty", 32'(empty), 1);
        chk("reset full", 32'(full), 0);
        chk("reset dmem_we", 32'(dmem_we), 0);
        chk("reset dmem_addr", dmem_addr, 0);
        chk("reset dmem_wdata", dmem_wdata, 0);
        chk("reset st_err", 32'(st_err), 0);
        chk("reset st_ready", 32'(st_ready), 1);
        @(posedge clk); #1;
        rst = 1'b1;

        // Table-driven vectors: comb outputs at the falling edge, registered after the rising edge
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].sv, tbl[i].sa, tbl[i].sd, tbl[i].lv, tbl[i].la);
            @(negedge clk);
            chk($sformatf("v%0d st_ready", i), 32'(st_ready), 32'(tbl[i].e_ready));
            chk($sformatf("v%0d ld_hit", i), 32'(ld_hit), 32'(tbl[i].e_hit));
            chk($sformatf("v%0d ld_fwd_data", i), ld_fwd_data, tbl[i].e_fwd);
            chk($sformatf("v%0d ld_stall", i), 32'(ld_stall), 32'(tbl[i].e_stall));
            @(posedge clk); #1;
            chk($sformatf("v%0d count", i), 32'(count), 32'(tbl[i].e_count));
            chk($sformatf("v%0d empty", i), 32'(empty), 32'(tbl[i].e_count == 3'd0));
            chk($sformatf("v%0d full", i), 32'(full), 32'(tbl[i].e_count == 3'd4));
            chk($sformatf("v%0d dmem_we", i), 32'(dmem_we), 32'(tbl[i].e_we));
            chk($sformatf("v%0d st_err", i), 32'(st_err), 32'(tbl[i].e_err));
            if (tbl[i].e_we) begin
                chk($sformatf("v%0d dmem_addr", i), dmem_addr, tbl[i].e_addr);
                chk($sformatf("v%0d dmem_wdata", i), dmem_wdata, tbl[i].e_wdata);
            end
            $display("vec %0d: st=%b@%h ld=%b@%h -> count=%0d we=%b addr=%h wdata=%h err=%b",
                     i, tbl[i].sv, tbl[i].sa, tbl[i].lv, tbl[i].la,
                     count, dmem_we, dmem_addr, dmem_wdata, st_err);
        end

        // Wrap: 10 stores back to back, no loads; one write per cycle, in order
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            drive(1, 32'h100 + 32'(4 * k), 32'h50000000 + 32'(k), 0, 0);
            @(posedge clk); #1;
            pulses += int'(dmem_we);
            chk($sformatf("wrap%0d count", k), 32'(count), 1);
            chk($sformatf("wrap%0d dmem_we", k), 32'(dmem_we), (k > 0) ? 32'd1 : 32'd0);
            if (k > 0) begin
                chk($sformatf("wrap%0d dmem_addr", k), dmem_addr, 32'h100 + 32'(4 * (k - 1)));
                chk($sformatf("wrap%0d dmem_wdata", k), dmem_wdata, 32'h50000000 + 32'(k - 1));
            end
            $display("wrap %0d: count=%0d we=%b addr=%h wdata=%h", k, count, dmem_we, dmem_addr, dmem_wdata);
        end
        drive(0, 0, 0, 0, 0);
        @(posedge clk); #1;
        pulses += int'(dmem_we);
        chk("wrap last dmem_addr", dmem_addr, 32'h124);
        chk("wrap last dmem_wdata", dmem_wdata, 32'h50000009);
        chk("wrap last count", 32'(count), 0);
        @(posedge clk); #1;
        pulses += int'(dmem_we);
        chk("wrap pulses", 32'(pulses), 10);
        $display("wrap done: pulses=%0d", pulses);

        // Reset mid-drain with 3 entries, then confirm nothing is written after release
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h40 + 32'(4 * k), 32'hE0000000 + 32'(k), 1, 0);
            @(posedge clk); #1;
        end
        drive(0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("pre-reset dmem_we", 32'(dmem_we), 1);
        chk("pre-reset dmem_addr", dmem_addr, 32'h40);
        chk("pre-reset count", 32'(count), 2);
        #2;
        rst = 1'b0;
        #1;
        chk("async reset count", 32'(count), 0);
        chk("async reset empty", 32'(empty), 1);
        chk("async reset dmem_we", 32'(dmem_we), 0);
        chk("async reset dmem_addr", dmem_addr, 0);
        $display("reset asserted mid-drain: count=%0d we=%b", count, dmem_we);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("post-reset%0d dmem_we", k), 32'(dmem_we), 0);
            chk($sformatf("post-reset%0d count", k), 32'(count), 0);
            $display("post-reset %0d: count=%0d we=%b", k, count, dmem_we);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_store_buffer.md
Name: dmem_store_buffer

Overview:
- Posted-write buffer between the EX/MEM pipeline register and the single-port, byte-addressed, big-endian data memory.
- Accepts word stores from the pipeline in one cycle and drains them to data memory in idle cycles, so loads take priority on the shared port.
- Forwards buffered store data to younger loads to the same word.
- Output side drives the data memory's addr/write_data/memwrite inputs directly.

Parameters:
- DEPTH, 4, number of store entries (power of 2, ≥2).
- AW, 32, address width.
- DW, 32, data width (word).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- st_valid  input  1  pipeline presents a store this cycle.
- st_addr  input  AW  store byte address; must be word-aligned.
- st_data  input  DW  store data.
- st_ready  output  1  buffer can accept a store (= !full).
- st_err  output  1  registered one-cycle pulse: misaligned store rejected.
- ld_valid  input  1  pipeline performs a load this cycle; data memory port is in use.
- ld_addr  input  AW  load byte address.
- ld_hit  output  1  combinational: a buffered entry matches ld_addr[AW-1:2].
- ld_fwd_data  output  DW  combinational: data of the youngest matching entry; 0 when no hit.
- ld_stall  output  1  combinational: ld_valid && full && !ld_hit.
- dmem_addr  output  AW  registered write address to data memory.
- dmem_wdata  output  DW  registered write data.
- dmem_we  output  1  registered one-cycle write strobe.
- count  output  log2(DEPTH)+1  current occupancy.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.

Behaviour:
- Reset (rst=0, async): head=tail=count=0. dmem_we=0, dmem_addr=0, dmem_wdata=0, st_err=0. Pending stores are discarded, including mid-drain; no dmem_we is issued after reset deasserts until a new store is accepted.
- Storage: circular FIFO of {word address, data}. head = oldest entry, tail = next free slot. Pointers wrap modulo DEPTH.
- Push: on an edge where st_valid && st_ready && st_addr[1:0]==0, write the entry at tail and advance tail.
- Misaligned store: st_valid && st_addr[1:0]!=0 → no push; st_err=1 for the following cycle.
- Store while full: st_ready=0 and the store is ignored. The pipeline must hold. st_ready reflects pre-edge state, so no push occurs while full even if a pop happens on the same edge.
- Drain FSM, states IDLE and WRITE:
  - A drain fires on an edge when !empty and (!ld_valid or full). On that edge, the head entry is registered into dmem_addr/dmem_wdata, dmem_we=1, head advances, and the state goes to WRITE.
  - In WRITE, dmem_we=1 for exactly one cycle. Next state is WRITE again if another drain fires, else IDLE with dmem_we=0.
  - Back-to-back drains give one write per cycle.
- Latency: a store accepted at edge N with no load pending appears on the dmem outputs from edge N+1. Minimum buffer residency is 1 cycle.
- Load priority: while ld_valid && !full, the drain is suppressed.
- Full and load together: the drain takes the port. If ld_hit, the load completes by forwarding and ld_stall=0. Otherwise ld_stall=1 and the pipeline replays the load next cycle.
- Forwarding:
  - Compare ld_addr[AW-1:2] against all valid entries. The youngest (closest to tail) wins.
  - The entry currently held in the dmem_* registers is not searched, since the data memory writes it the same cycle.
  - Whole-word forward only; ld_addr[1:0] is ignored.
- Simultaneous push and pop: count unchanged, both pointers advance.
- count: a push alone increments it; a pop alone decrements it. It never exceeds DEPTH or underflows.

Optional Feature:
- Macro: STBUF_COALESCE_EN.
- Defined: a store whose word address equals the youngest valid entry (tail-1) overwrites that entry's data instead of allocating. This applies when that entry is not being popped on the same edge; count is unchanged. Coalescing is also permitted when full, so st_ready = !full || coalesce-match.
- Undefined: every accepted store allocates a new entry.

Test Plan:
- Reset: assert rst=0 mid-drain with 3 entries → count=0, empty=1, dmem_we=0 immediately; no write occurs after release.
- Basic drain: store 0x0000_0008 ← 0xDEADBEEF, ld_valid=0 → next cycle dmem_we=1, dmem_addr=0x8, dmem_wdata=0xDEADBEEF, then empty=1.
- Load priority and forward:
  - Setup: stores to 0x10 (0x11111111) then 0x10 (0x22222222) with ld_valid held high.
  - Load 0x12 → ld_hit=1, ld_fwd_data=0x22222222, no dmem_we while not full.
  - With macro defined: count=1.
- Full stall:
  - Setup: hold ld_valid, push 4 stores (0x0, 0x4, 0x8, 0xC).
  - Then full=1, st_ready=0; a 5th store is ignored.
  - Load 0x20 → ld_stall=1 and drain of 0x0 begins.
- Misaligned: store to 0x0000_0006 → st_err=1 for one cycle, count unchanged.
- Wrap: 10 consecutive stores at one store per cycle with no loads → 10 dmem_we pulses, in order, with correct data; count never exceeds 1.
